// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 single-bit mux with registered grant/select.
// Optional per-winner hold limit enabled by defining ARB_HOLD_LIMIT_EN (limit = HOLD_MAX cycles).
module mux_rr_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] data_i,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       valid,
    output logic       data_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] gnt_r;
    logic [3:0] gnt_nxt_s;
    logic [1:0] sel_r;
    logic [1:0] sel_nxt_s;
    logic       valid_r;
    logic       valid_nxt_s;
    logic [1:0] last_r;
    logic [1:0] last_nxt_s;
    logic [3:0] cand_s;
    logic [2:0] pick_s;
    logic       load_s;
    logic       rotate_s;
    logic [3:0] sel_dec_s;

    // Returns {found, index} of the first set candidate after 'last', wrapping modulo 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = last + 2'(i + 1);
            if (cand[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // The current owner never competes against itself, so a rotation always moves on.
    assign cand_s = req & ~gnt_r;
    assign pick_s = rr_pick(cand_s, last_r);

`ifdef ARB_HOLD_LIMIT_EN
    localparam int CW = $clog2(HOLD_MAX + 1);

    logic [CW-1:0] hold_cnt_r;
    logic [CW-1:0] hold_cnt_nxt_s;

    assign rotate_s = (hold_cnt_r >= CW'(HOLD_MAX)) && (|cand_s);

    // Hold counter next value: 1 on a new grant, saturating count while held, 0 when idle.
    always_comb begin
        hold_cnt_nxt_s = hold_cnt_r;
        if (load_s) begin
            hold_cnt_nxt_s = CW'(1);
        end else if (state_nxt_s == GRANT) begin
            if (hold_cnt_r < CW'(HOLD_MAX)) begin
                hold_cnt_nxt_s = hold_cnt_r + CW'(1);
            end else begin
                hold_cnt_nxt_s = hold_cnt_r;
            end
        end else begin
            hold_cnt_nxt_s = {CW{1'b0}};
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r <= {CW{1'b0}};
        end else begin
            hold_cnt_r <= hold_cnt_nxt_s;
        end
    end
`else
    assign rotate_s = 1'b0;
`endif

    // Next-state and grant selection; a release with other requests pending regrants on the same edge.
    always_comb begin
        state_nxt_s = state_r;
        gnt_nxt_s   = gnt_r;
        sel_nxt_s   = sel_r;
        valid_nxt_s = valid_r;
        last_nxt_s  = last_r;
        load_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_s[2]) begin
                    load_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GRANT: begin
                if (!req[sel_r] || rotate_s) begin
                    if (pick_s[2]) begin
                        load_s = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                        gnt_nxt_s   = 4'b0000;
                        valid_nxt_s = 1'b0;
                    end
                end else begin
                    state_nxt_s = GRANT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                gnt_nxt_s   = 4'b0000;
                valid_nxt_s = 1'b0;
            end
        endcase
        if (load_s) begin
            state_nxt_s = GRANT;
            gnt_nxt_s   = 4'b0001 << pick_s[1:0];
            sel_nxt_s   = pick_s[1:0];
            valid_nxt_s = 1'b1;
            last_nxt_s  = pick_s[1:0];
        end else begin
            last_nxt_s  = last_r;
        end
    end

    // State, grant and round-robin pointer registers; pointer resets so requester 0 is first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            gnt_r   <= 4'b0000;
            sel_r   <= 2'b00;
            valid_r <= 1'b0;
            last_r  <= 2'b11;
        end else begin
            state_r <= state_nxt_s;
            gnt_r   <= gnt_nxt_s;
            sel_r   <= sel_nxt_s;
            valid_r <= valid_nxt_s;
            last_r  <= last_nxt_s;
        end
    end

    assign sel_dec_s = 4'b0001 << sel_r;
    assign data_o    = valid_r & (|(data_i & sel_dec_s));
    assign gnt       = gnt_r;
    assign sel       = sel_r;
    assign valid     = valid_r;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural owner/pointer model.
module tb_mux_rr_arbiter;

    localparam int HOLD_MAX = 4;
`ifdef ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [3:0] req    = 4'b0000;
    logic [3:0] data_i = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       data_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: owner index (-1 = none), last winner, visible select, cycles held.
    int m_owner = -1;
    int m_last  = 3;
    int m_sel   = 0;
    int m_cnt   = 0;

    int exp_order [5] = '{0, 1, 2, 3, 0};
    int got_order [5];

    always #5 clk = ~clk;

    mux_rr_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .data_i (data_i),
        .gnt    (gnt),
        .sel    (sel),
        .valid  (valid),
        .data_o (data_o)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [3:0] r, input int last, input int excl);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (last + k) % 4;
            if (r[idx] && idx != excl) return idx;
        end
        return -1;
    endfunction

    function automatic bit owner_req(input logic [3:0] r, input int owner);
        if (owner < 0) return 1'b0;
        return r[owner];
    endfunction

    function automatic logic [3:0] exp_gnt();
        if (m_owner < 0) return 4'b0000;
        return 4'b0001 << m_owner;
    endfunction

    // Reference model: keep the owner while it requests (and is under the hold limit), else pick anew.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_last  <= 3;
            m_sel   <= 0;
            m_cnt   <= 0;
        end else if (owner_req(req, m_owner) &&
                     !(HOLD_EN && m_cnt >= HOLD_MAX && pick(req, m_last, m_owner) >= 0)) begin
            m_cnt <= (m_cnt < HOLD_MAX) ? m_cnt + 1 : m_cnt;
        end else if (pick(req, m_last, m_owner) >= 0) begin
            m_owner <= pick(req, m_last, m_owner);
            m_last  <= pick(req, m_last, m_owner);
            m_sel   <= pick(req, m_last, m_owner);
            m_cnt   <= 1;
        end else begin
            m_owner <= -1;
            m_cnt   <= 0;
        end
    end

    // Per-cycle comparison of every output against the model, away from the active edge.
    always @(negedge clk) begin
        check("gnt", gnt, exp_gnt());
        check("sel", {2'b00, sel}, 4'(m_sel));
        check("valid", {3'b000, valid}, {3'b000, (m_owner >= 0)});
        check("data_o", {3'b000, data_o}, {3'b000, ((m_owner >= 0) && data_i[m_sel])});
    end

    initial begin
        // Reset with all requesters asking.
        req = 4'b1111;
        cyc();
        cyc();
        check("rst_gnt", gnt, 4'b0000);
        check("rst_sel", {2'b00, sel}, 4'b0000);
        check("rst_valid", {3'b000, valid}, 4'b0000);
        check("rst_data_o", {3'b000, data_o}, 4'b0000);
        rst_n = 1'b1;
        cyc();
        check("t1_gnt", gnt, 4'b0001);
        check("t1_sel", {2'b00, sel}, 4'b0000);

        // Rotation: each owner drops its request for one cycle after one grant cycle.
        got_order[0] = int'(sel);
        for (int i = 1; i < 5; i++) begin
            req = 4'b1111 & ~gnt;
            cyc();
            got_order[i] = int'(sel);
            check("t2_valid", {3'b000, valid}, 4'b0001);
        end
        for (int i = 0; i < 5; i++) begin
            check("t2_order", 4'(got_order[i]), 4'(exp_order[i]));
        end

        // Wrap from 3 to 0, then data routing.
        req = 4'b1000;
        cyc();
        check("t3_gnt3", gnt, 4'b1000);
        req    = 4'b0101;
        data_i = 4'b0100;
        cyc();
        check("t3_gnt0", gnt, 4'b0001);
        check("t3_data0", {3'b000, data_o}, 4'b0000);
        req = 4'b0100;
        cyc();
        check("t3_gnt2", gnt, 4'b0100);
        check("t3_sel2", {2'b00, sel}, 4'b0010);
        check("t3_data2", {3'b000, data_o}, 4'b0001);

        // Idle: single three-cycle request pulse, select retained after release.
        req = 4'b0000;
        cyc();
        check("t4_idle", {3'b000, valid}, 4'b0000);
        req = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t4_gnt1", gnt, 4'b0010);
        end
        req = 4'b0000;
        cyc();
        check("t4_gnt_off", gnt, 4'b0000);
        check("t4_valid_off", {3'b000, valid}, 4'b0000);
        check("t4_data_off", {3'b000, data_o}, 4'b0000);
        check("t4_sel_kept", {2'b00, sel}, 4'b0001);

        // Asynchronous reset in the middle of a grant.
        req    = 4'b0100;
        data_i = 4'b1111;
        cyc();
        check("t5_gnt2", gnt, 4'b0100);
        req = 4'b1111;
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_gnt", gnt, 4'b0000);
        check("t5_async_valid", {3'b000, valid}, 4'b0000);
        check("t5_async_sel", {2'b00, sel}, 4'b0000);
        check("t5_async_data", {3'b000, data_o}, 4'b0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();
        check("t5_restart", gnt, 4'b0001);

        // Hold limit: two persistent requesters, starting just after a grant to 3.
        req = 4'b1000;
        cyc();
        check("t6_gnt3", gnt, 4'b1000);
        req = 4'b0101;
        for (int i = 0; i < 16; i++) begin
            cyc();
            check("t6_hold", gnt, (HOLD_EN && ((i / 4) % 2 == 1)) ? 4'b0100 : 4'b0001);
        end

        // Randomized traffic with persistent requests and one mid-cycle reset pulse.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
            data_i = 4'($urandom_range(0, 15));
            if (i == 200) begin
                #3 rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
            end else begin
                cyc();
            end
        end
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
